// File: rtl/a_pass_entry.sv
// Keypad-side password entry: shifts four digits into a 16-bit attempt, holds it for the
// checker, counts consecutive failures and runs a tick-timed lockout after too many.
module a_pass_entry #(
  parameter int unsigned MAX_FAIL      = 3,
  parameter int unsigned LOCKOUT_TICKS = 500
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        tick_i,
  input  logic        key_valid_i,
  input  logic [3:0]  key_code_i,
  input  logic        key_clear_i,
  input  logic        gen_rst_i,
  input  logic        enb_lock_i,
  output logic [15:0] pw_16bit_o,
  output logic        enough_o,
  output logic        disable_cnt_o,
  output logic [2:0]  digit_cnt_o,
  output logic [2:0]  fail_cnt_o
);

  typedef enum logic [1:0] {StEntry, StFull, StLockout, StOpen} state_e;

  localparam logic [2:0]  FailLast  = 3'(MAX_FAIL - 1);
  localparam logic [15:0] LockTicks = 16'(LOCKOUT_TICKS);

  state_e      state_q, state_d;
  logic [15:0] pw_q, pw_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  digit_q, digit_d;
  logic [2:0]  fail_q, fail_d;
  logic        enough_q, disable_q;

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    timer_d = timer_q;
    digit_d = digit_q;
    fail_d  = fail_q;
    unique case (state_q)
      StEntry: begin
        // Clear has priority; a key strobed alongside it is dropped.
        if (key_clear_i) begin
          pw_d    = '0;
          digit_d = '0;
        end else if (key_valid_i) begin
          pw_d    = {pw_q[11:0], key_code_i};
          digit_d = digit_q + 3'd1;
          if (digit_q == 3'd3) state_d = StFull;
        end
      end
      StFull: begin
        if (gen_rst_i) begin
          pw_d    = '0;
          digit_d = '0;
          if (enb_lock_i) begin
            state_d = StOpen;
            fail_d  = '0;
          end else if (fail_q == FailLast) begin
            state_d = StLockout;
            fail_d  = '0;
            timer_d = LockTicks;
          end else begin
            state_d = StEntry;
            fail_d  = fail_q + 3'd1;
          end
        end
      end
      StLockout: begin
        if (tick_i) begin
          if (timer_q == 16'd1) begin
            state_d = StEntry;
            timer_d = '0;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
      end
      StOpen: begin
        if (!enb_lock_i) state_d = StEntry;
      end
      default: state_d = StEntry;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StEntry;
      pw_q      <= '0;
      timer_q   <= '0;
      digit_q   <= '0;
      fail_q    <= '0;
      enough_q  <= 1'b0;
      disable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pw_q      <= pw_d;
      timer_q   <= timer_d;
      digit_q   <= digit_d;
      fail_q    <= fail_d;
      // Flags track the next state so they are registered yet change on the same edge.
      enough_q  <= (state_d == StFull);
      disable_q <= (state_d == StLockout);
    end
  end

  assign pw_16bit_o    = pw_q;
  assign enough_o      = enough_q;
  assign disable_cnt_o = disable_q;
  assign digit_cnt_o   = digit_q;
  assign fail_cnt_o    = fail_q;

endmodule

// File: tb/tb_a_pass_entry.sv
// Scoreboard bench for a_pass_entry: a digit-list reference model predicts outputs per edge,
// a monitor pops and compares them after each edge.
module tb_a_pass_entry;

  localparam int unsigned MaxFail   = 3;
  localparam int unsigned LockTicks = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0, key_valid = 1'b0, key_clear = 1'b0, gen_rst = 1'b0, enb_lock = 1'b0;
  logic [3:0]  key_code = '0;
  logic [15:0] pw_16bit;
  logic        enough, disable_cnt;
  logic [2:0]  digit_cnt, fail_cnt;

  a_pass_entry #(
    .MAX_FAIL     (MaxFail),
    .LOCKOUT_TICKS(LockTicks)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .tick_i       (tick),
    .key_valid_i  (key_valid),
    .key_code_i   (key_code),
    .key_clear_i  (key_clear),
    .gen_rst_i    (gen_rst),
    .enb_lock_i   (enb_lock),
    .pw_16bit_o   (pw_16bit),
    .enough_o     (enough),
    .disable_cnt_o(disable_cnt),
    .digit_cnt_o  (digit_cnt),
    .fail_cnt_o   (fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tgt;
    logic [15:0] pw;
    logic        en;
    logic        dis;
    logic [2:0]  dc;
    logic [2:0]  fc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc_n = 0;

  // Reference model: 0 entering, 1 attempt held, 2 locked out, 3 door open.
  int mode;
  int digs[$];
  int fails;
  int left;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mode = 0;
    digs.delete();
    fails = 0;
    left = 0;
  endfunction

  function automatic void model_step(input logic kv, input logic [3:0] code, input logic clr,
                                     input logic gr, input logic enb, input logic tk);
    case (mode)
      0: begin
        if (clr) digs.delete();
        else if (kv) begin
          digs.push_back(int'(code));
          if (digs.size() == 4) mode = 1;
        end
      end
      1: begin
        if (gr) begin
          digs.delete();
          if (enb) begin
            mode = 3;
            fails = 0;
          end else if (fails + 1 == int'(MaxFail)) begin
            mode = 2;
            fails = 0;
            left = int'(LockTicks);
          end else begin
            mode = 0;
            fails++;
          end
        end
      end
      2: begin
        if (tk) begin
          left--;
          if (left == 0) mode = 0;
        end
      end
      default: if (!enb) mode = 0;
    endcase
  endfunction

  function automatic exp_t model_out(input int tgt);
    exp_t e;
    int   word = 0;
    foreach (digs[i]) word = word * 16 + digs[i];
    e.tgt = tgt;
    e.pw  = word[15:0];
    e.en  = (mode == 1);
    e.dis = (mode == 2);
    e.dc  = 3'(digs.size());
    e.fc  = 3'(fails);
    return e;
  endfunction

  task automatic cyc(input logic kv, input logic [3:0] code, input logic clr, input logic gr,
                     input logic enb, input logic tk);
    @(posedge clk);
    #1;
    key_valid = kv;
    key_code  = code;
    key_clear = clr;
    gen_rst   = gr;
    enb_lock  = enb;
    tick      = tk;
    model_step(kv, code, clr, gr, enb, tk);
    sb.push_back(model_out(cyc_n + 1));
  endtask

  task automatic key(input logic [3:0] code);
    cyc(1'b1, code, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter4(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) key(w[i*4 +: 4]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pw"}, pw_16bit, 16'h0);
    check({tag, "_enough"}, 16'(enough), 16'h0);
    check({tag, "_disable"}, 16'(disable_cnt), 16'h0);
    check({tag, "_digit_cnt"}, 16'(digit_cnt), 16'h0);
    check({tag, "_fail_cnt"}, 16'(fail_cnt), 16'h0);
  endtask

  // Monitor: after each edge compare every expectation that targets this edge.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      while (sb.size() > 0 && sb[0].tgt <= cyc_n) begin
        mon_e = sb.pop_front();
        check("pw_16bit", pw_16bit, mon_e.pw);
        check("enough", 16'(enough), 16'(mon_e.en));
        check("disable_cnt", 16'(disable_cnt), 16'(mon_e.dis));
        check("digit_cnt", 16'(digit_cnt), 16'(mon_e.dc));
        check("fail_cnt", 16'(fail_cnt), 16'(mon_e.fc));
      end
    end
  end

  initial begin
    model_reset();
    #2;
    check_zero("reset");
    #21;
    reset_n = 1'b1;

    // Basic entry, then keys ignored while full.
    enter4(16'h1234);
    key(4'h9);
    key(4'h9);
    idle(1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);   // wrong -> fail 1

    // Partial entry discarded by clear.
    key(4'hA);
    key(4'hB);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    enter4(16'h5678);
    idle(1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);   // wrong -> fail 2

    // Clear together with a key at two digits drops the key.
    key(4'h1);
    key(4'h2);
    cyc(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    enter4(16'hCAFE);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);   // match -> open, fails cleared
    cyc(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);   // leaves open, key still ignored
    key(4'h7);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Three failures with gen_rst held three cycles; then timed lockout.
    for (int a = 0; a < 3; a++) begin
      enter4(16'h0F0F);
      for (int h = 0; h < 3; h++) cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    for (int t = 0; t < 4; t++) begin
      cyc(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    enter4(16'h4321);

    // Second lockout abandoned by an asynchronous reset between edges.
    for (int a = 0; a < 3; a++) begin
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (a < 2) enter4(16'h1111);
    end
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #4;
    {key_valid, key_clear, gen_rst, enb_lock, tick} = '0;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check_zero("async_reset");
    #2;
    reset_n = 1'b1;
    model_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 3) == 0, 4'($urandom), ($urandom % 16) == 0, ($urandom % 4) == 0,
          ($urandom % 3) == 0, ($urandom % 2) == 0);
    end
    idle(2);
    @(posedge clk);
    #4;
    check("sb_drain", 16'(sb.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
